wishbone_4mst_to_1slv: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 10 +
 rtl/wb_rr_picker.sv | 28 ++
 rtl/wishbone_4mst_to_1slv.sv | 161 ++++++++++++++++
 tb/tb_wishbone_4mst_to_1slv.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and state encoding for the 4-master Wishbone arbiter.
package wb_arb_pkg;
    localparam int          NUM_MST          = 4;
    localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: first requester after i_last (wrapping), one-hot plus index.
module wb_rr_picker
    import wb_arb_pkg::*;
(
    input  logic [NUM_MST-1:0] i_req,
    input  logic [1:0]         i_last,
    output logic [NUM_MST-1:0] o_grant,
    output logic [1:0]         o_idx,
    output logic               o_any
);
    logic [1:0] w_cand;

    // Scan last+1, last+2, ... last+4 (=last) and keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = i_last;
        o_any   = 1'b0;
        w_cand  = i_last;
        for (int k = 1; k <= NUM_MST; k++) begin
            w_cand = i_last + 2'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wishbone_4mst_to_1slv.sv
// Wishbone classic 4-master to 1-slave arbiter. Round-robin, registered grant,
// bus locked to the granted master for its whole CYC, one dead IDLE cycle
// between owners. Optional slave-ack watchdog enabled by WB_ARB_TIMEOUT_EN.
module wishbone_4mst_to_1slv
    import wb_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = DEF_TIMEOUT_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_m0_cyc_i,
    input  logic        wbs_m0_stb_i,
    input  logic [31:0] wbs_m0_adr_i,
    input  logic        wbs_m0_we_i,
    input  logic [31:0] wbs_m0_dat_i,
    input  logic [3:0]  wbs_m0_sel_i,
    output logic [31:0] wbs_m0_dat_o,
    output logic        wbs_m0_ack_o,
    input  logic        wbs_m1_cyc_i,
    input  logic        wbs_m1_stb_i,
    input  logic [31:0] wbs_m1_adr_i,
    input  logic        wbs_m1_we_i,
    input  logic [31:0] wbs_m1_dat_i,
    input  logic [3:0]  wbs_m1_sel_i,
    output logic [31:0] wbs_m1_dat_o,
    output logic        wbs_m1_ack_o,
    input  logic        wbs_m2_cyc_i,
    input  logic        wbs_m2_stb_i,
    input  logic [31:0] wbs_m2_adr_i,
    input  logic        wbs_m2_we_i,
    input  logic [31:0] wbs_m2_dat_i,
    input  logic [3:0]  wbs_m2_sel_i,
    output logic [31:0] wbs_m2_dat_o,
    output logic        wbs_m2_ack_o,
    input  logic        wbs_m3_cyc_i,
    input  logic        wbs_m3_stb_i,
    input  logic [31:0] wbs_m3_adr_i,
    input  logic        wbs_m3_we_i,
    input  logic [31:0] wbs_m3_dat_i,
    input  logic [3:0]  wbs_m3_sel_i,
    output logic [31:0] wbs_m3_dat_o,
    output logic        wbs_m3_ack_o,
    output logic        wbs_s_cyc_o,
    output logic        wbs_s_stb_o,
    output logic        wbs_s_we_o,
    output logic [31:0] wbs_s_adr_o,
    output logic [31:0] wbs_s_dat_o,
    output logic [3:0]  wbs_s_sel_o,
    input  logic [31:0] wbs_s_dat_i,
    input  logic        wbs_s_ack_i,
    output logic [3:0]  grant_o
);
    logic [NUM_MST-1:0]       w_cyc, w_stb, w_we, w_req, w_pick, w_ack;
    logic [NUM_MST-1:0][31:0] w_adr, w_wdat, w_rdat;
    logic [NUM_MST-1:0][3:0]  w_sel;
    logic [1:0]               w_pick_idx, w_last_nxt, r_last;
    logic                     w_any, w_fire;
    logic [NUM_MST-1:0]       r_grant, w_grant_nxt;
    state_t                   r_state, w_state_nxt;

    assign w_cyc  = {wbs_m3_cyc_i, wbs_m2_cyc_i, wbs_m1_cyc_i, wbs_m0_cyc_i};
    assign w_stb  = {wbs_m3_stb_i, wbs_m2_stb_i, wbs_m1_stb_i, wbs_m0_stb_i};
    assign w_we   = {wbs_m3_we_i,  wbs_m2_we_i,  wbs_m1_we_i,  wbs_m0_we_i};
    assign w_adr  = {wbs_m3_adr_i, wbs_m2_adr_i, wbs_m1_adr_i, wbs_m0_adr_i};
    assign w_wdat = {wbs_m3_dat_i, wbs_m2_dat_i, wbs_m1_dat_i, wbs_m0_dat_i};
    assign w_sel  = {wbs_m3_sel_i, wbs_m2_sel_i, wbs_m1_sel_i, wbs_m0_sel_i};
    assign w_req  = w_cyc & w_stb;

    wb_rr_picker u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // State, grant and last-owner registers. While BUSY, r_last is the owner.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state: arbitrate from IDLE, release when the owner drops CYC.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: if (w_any) begin
                w_state_nxt = BUSY;
                w_grant_nxt = w_pick;
                w_last_nxt  = w_pick_idx;
            end
            BUSY: if (!w_cyc[r_last]) begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    // The forced ack lands on the TIMEOUT_CYCLES-th stalled cycle, so the
    // compare is against the count of stalls already seen (limit - 1).
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wdog;
    logic        w_stall;

    assign w_stall = (r_state == BUSY) && w_stb[r_last] && !wbs_s_ack_i;
    assign w_fire  = w_stall && (r_wdog == TO_LAST);

    // Watchdog: count stalled strobe cycles, clear on ack, stb low, IDLE or fire.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)               r_wdog <= '0;
        else if (w_stall && !w_fire) r_wdog <= r_wdog + 16'd1;
        else                        r_wdog <= '0;
    end
`else
    assign w_fire = 1'b0;
`endif

    // Bus routing: owner drives the slave, slave response returns to owner only.
    always_comb begin
        wbs_s_cyc_o = 1'b0;
        wbs_s_stb_o = 1'b0;
        wbs_s_we_o  = w_we[0];
        wbs_s_adr_o = w_adr[0];
        wbs_s_dat_o = w_wdat[0];
        wbs_s_sel_o = w_sel[0];
        w_ack       = '0;
        w_rdat      = '0;
        if (r_state == BUSY) begin
            wbs_s_cyc_o    = w_cyc[r_last];
            wbs_s_stb_o    = w_stb[r_last] & ~w_fire;
            wbs_s_we_o     = w_we[r_last];
            wbs_s_adr_o    = w_adr[r_last];
            wbs_s_dat_o    = w_wdat[r_last];
            wbs_s_sel_o    = w_sel[r_last];
            w_ack[r_last]  = wbs_s_ack_i | w_fire;
            w_rdat[r_last] = w_fire ? TIMEOUT_DATA : wbs_s_dat_i;
        end
    end

    assign {wbs_m3_ack_o, wbs_m2_ack_o, wbs_m1_ack_o, wbs_m0_ack_o} = w_ack;
    assign wbs_m0_dat_o = w_rdat[0];
    assign wbs_m1_dat_o = w_rdat[1];
    assign wbs_m2_dat_o = w_rdat[2];
    assign wbs_m3_dat_o = w_rdat[3];
    assign grant_o      = r_grant;
endmodule

// File: tb/tb_wishbone_4mst_to_1slv.sv
// Bench for wishbone_4mst_to_1slv: directed stimulus, transaction-level model
// checked every cycle, plus literal expectations. Timeout part needs WB_ARB_TIMEOUT_EN.
module tb_wishbone_4mst_to_1slv;
    localparam int          TO  = 4;
    localparam logic [31:0] TOD = 32'hDEADBEEF;

    logic        clk = 1'b0, rst = 1'b1;
    logic        m_cyc[4], m_stb[4], m_we[4], m_ack[4];
    logic [31:0] m_adr[4], m_dat[4], m_dato[4];
    logic [3:0]  m_sel[4];
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_dato, s_dati;
    logic [3:0]  s_sel, grant_o;

    int npass = 0, nchk = 0;
    bit cmp_en = 0;
    int mg = -1, mlast = 3, mcnt = 0;

    always #5 clk = ~clk;

    wishbone_4mst_to_1slv #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TOD)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_m0_cyc_i(m_cyc[0]), .wbs_m0_stb_i(m_stb[0]), .wbs_m0_adr_i(m_adr[0]),
        .wbs_m0_we_i(m_we[0]), .wbs_m0_dat_i(m_dat[0]), .wbs_m0_sel_i(m_sel[0]),
        .wbs_m0_dat_o(m_dato[0]), .wbs_m0_ack_o(m_ack[0]),
        .wbs_m1_cyc_i(m_cyc[1]), .wbs_m1_stb_i(m_stb[1]), .wbs_m1_adr_i(m_adr[1]),
        .wbs_m1_we_i(m_we[1]), .wbs_m1_dat_i(m_dat[1]), .wbs_m1_sel_i(m_sel[1]),
        .wbs_m1_dat_o(m_dato[1]), .wbs_m1_ack_o(m_ack[1]),
        .wbs_m2_cyc_i(m_cyc[2]), .wbs_m2_stb_i(m_stb[2]), .wbs_m2_adr_i(m_adr[2]),
        .wbs_m2_we_i(m_we[2]), .wbs_m2_dat_i(m_dat[2]), .wbs_m2_sel_i(m_sel[2]),
        .wbs_m2_dat_o(m_dato[2]), .wbs_m2_ack_o(m_ack[2]),
        .wbs_m3_cyc_i(m_cyc[3]), .wbs_m3_stb_i(m_stb[3]), .wbs_m3_adr_i(m_adr[3]),
        .wbs_m3_we_i(m_we[3]), .wbs_m3_dat_i(m_dat[3]), .wbs_m3_sel_i(m_sel[3]),
        .wbs_m3_dat_o(m_dato[3]), .wbs_m3_ack_o(m_ack[3]),
        .wbs_s_cyc_o(s_cyc), .wbs_s_stb_o(s_stb), .wbs_s_we_o(s_we),
        .wbs_s_adr_o(s_adr), .wbs_s_dat_o(s_dato), .wbs_s_sel_o(s_sel),
        .wbs_s_dat_i(s_dati), .wbs_s_ack_i(s_ack), .grant_o(grant_o)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Watchdog forces an ack on the TO-th consecutive stalled strobe cycle.
    function automatic bit mfire();
`ifdef WB_ARB_TIMEOUT_EN
        return (mg >= 0) && m_stb[mg] && !s_ack && (mcnt == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: owner index (-1 idle), last owner, stall count.
    always @(posedge clk) begin
        bit f;
        bit found;
        int c;
        f = mfire();
        if (rst) begin
            mg = -1; mlast = 3; mcnt = 0;
        end else begin
            if (mg >= 0 && m_stb[mg] && !s_ack && !f) mcnt++;
            else mcnt = 0;
            if (mg < 0) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    c = (mlast + k) % 4;
                    if (!found && m_cyc[c] && m_stb[c]) begin
                        found = 1; mg = c; mlast = c;
                    end
                end
            end else if (!m_cyc[mg]) begin
                mg = -1;
            end
        end
    end

    // Compare all DUT outputs against the model every cycle.
    always @(negedge clk) begin
        int src;
        bit f;
        if (cmp_en) begin
            f   = mfire();
            src = (mg < 0) ? 0 : mg;
            check("grant", 32'(grant_o), (mg < 0) ? 32'd0 : 32'(1 << mg));
            check("s_cyc", 32'(s_cyc), (mg < 0) ? 32'd0 : 32'(m_cyc[mg]));
            check("s_stb", 32'(s_stb), (mg < 0) ? 32'd0 : 32'(m_stb[mg] && !f));
            check("s_we",  32'(s_we),  32'(m_we[src]));
            check("s_adr", s_adr,      m_adr[src]);
            check("s_dat", s_dato,     m_dat[src]);
            check("s_sel", 32'(s_sel), 32'(m_sel[src]));
            for (int k = 0; k < 4; k++) begin
                check("m_ack", 32'(m_ack[k]), 32'(k == mg && (s_ack || f)));
                check("m_dat", m_dato[k], (k == mg) ? (f ? TOD : s_dati) : 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input int n, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[n] = cyc; m_stb[n] = stb; m_we[n] = we;
        m_adr[n] = adr; m_dat[n] = dat; m_sel[n] = 4'hF;
    endtask

    task automatic waitgrant(input string nm, input logic [3:0] exp);
        for (int i = 0; i < 6 && grant_o == 4'd0; i++) step();
        check(nm, 32'(grant_o), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) drive(k, 0, 0, 0, 32'd0, 32'd0);
        s_ack = 0; s_dati = 0;
        step(); step();
        cmp_en = 1; rst = 0;
        #3 check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_scyc", 32'(s_cyc), 32'd0);

        // Single master write from m2
        drive(2, 1, 1, 1, 32'h3000_0004, 32'h1234_5678);
        #1 check("t1_pre_stb", 32'(s_stb), 32'd0);
        step();
        #3 check("t1_stb", 32'(s_stb), 32'd1);
        check("t1_grant", 32'(grant_o), 32'h4);
        check("t1_adr", s_adr, 32'h3000_0004);
        check("t1_wdat", s_dato, 32'h1234_5678);
        step(); step();
        s_ack = 1;
        #3 check("t1_ack", 32'(m_ack[2]), 32'd1);
        check("t1_m0ack", 32'(m_ack[0]), 32'd0);
        step();
        drive(2, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
        step();
        #3 check("t1_idle", 32'(grant_o), 32'd0);

        // Simultaneous reads out of reset
        rst = 1; step(); rst = 0;
        for (int k = 0; k < 4; k++) drive(k, 1, 1, 0, 32'(k * 4), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            waitgrant("t2_grant", 4'(1 << k));
            s_ack = 1; s_dati = 32'hA0 + 32'(k);
            #3 check("t2_ack", 32'(m_ack[k]), 32'd1);
            check("t2_dat", m_dato[k], 32'hA0 + 32'(k));
            step();
            drive(k, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
            step();
            #3 check("t2_gap", 32'(grant_o), 32'd0);
            step();
        end

        // Lock: m1 holds the bus for 3 beats while m3 waits
        drive(1, 1, 1, 0, 32'h20, 32'd0);
        drive(3, 1, 1, 0, 32'h40, 32'd0);
        step();
        waitgrant("t3_grant", 4'h2);
        for (int b = 0; b < 3; b++) begin
            s_ack = 1; s_dati = 32'hB0 + 32'(b);
            #3 check("t3_m1dat", m_dato[1], 32'hB0 + 32'(b));
            check("t3_m3ack", 32'(m_ack[3]), 32'd0);
            check("t3_m3dat", m_dato[3], 32'd0);
            step();
        end
        s_ack = 0; drive(1, 0, 0, 0, 32'd0, 32'd0);
        step();
        #3 check("t3_gap", 32'(grant_o), 32'd0);
        step();
        waitgrant("t3_m3", 4'h8);
        s_ack = 1; s_dati = 32'hC3;
        step();
        drive(3, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
        step(); step();

        // Fairness: after m3, m0 beats m3
        drive(3, 1, 1, 0, 32'h44, 32'd0);
        drive(0, 1, 1, 0, 32'h04, 32'd0);
        step();
        waitgrant("t4_rr", 4'h1);
        s_ack = 1; s_dati = 32'hD0;
        step();
        drive(0, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
        step(); step();
        waitgrant("t4_m3", 4'h8);
        s_ack = 1; s_dati = 32'hD3;
        step();
        drive(3, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
        step(); step();

        // Reset in the middle of an m2 transfer
        drive(2, 1, 1, 1, 32'h50, 32'h55);
        step();
        waitgrant("t5_grant", 4'h4);
        #3 check("t5_stb", 32'(s_stb), 32'd1);
        rst = 1; step(); rst = 0;
        drive(0, 1, 1, 0, 32'h60, 32'd0);
        #3 check("t5_scyc", 32'(s_cyc), 32'd0);
        check("t5_grant0", 32'(grant_o), 32'd0);
        step();
        check("t5_rr", 32'(grant_o), 32'h1);
        s_ack = 1; s_dati = 32'hE0;
        step();
        drive(0, 0, 0, 0, 32'd0, 32'd0); drive(2, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
        step(); step();

        // Slave never acks a read from m1
        drive(1, 1, 1, 0, 32'h70, 32'd0);
        step();
        waitgrant("t6_grant", 4'h2);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            #3 check("t6_stall_ack", 32'(m_ack[1]), 32'd0);
            step();
        end
        #3 check("t6_to_ack", 32'(m_ack[1]), 32'd1);
        check("t6_to_dat", m_dato[1], 32'hDEADBEEF);
        check("t6_to_stb", 32'(s_stb), 32'd0);
        step();
        #3 check("t6_resume_stb", 32'(s_stb), 32'd1);
`else
        for (int c = 0; c < 6; c++) begin
            #3 check("t6_wait_ack", 32'(m_ack[1]), 32'd0);
            step();
        end
`endif
        s_ack = 1; s_dati = 32'h77;
        #1 check("t6_real_dat", m_dato[1], 32'h77);
        step();
        drive(1, 0, 0, 0, 32'd0, 32'd0); s_ack = 0;
        step(); step();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
